// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO controller: per-pin direction, synchronised readback, set/clear/toggle
// output writes and per-pin edge/level interrupts merged onto a single registered irq line.
module wb_gpio_irq #(
    parameter int unsigned           GPIO_WIDTH  = 32,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    inout  logic [GPIO_WIDTH-1:0] gpio_b,
    output logic                  irq_o
);

    typedef enum logic [2:0] {
        A_DATA_OUT = 3'd0,
        A_DIR      = 3'd1,
        A_DATA_IN  = 3'd2,
        A_OUT_SET  = 3'd3,
        A_OUT_CLR  = 3'd4,
        A_OUT_TGL  = 3'd5,
        A_IRQ_EN   = 3'd6,
        A_IRQ_CFG  = 3'd7
    } reg_addr_e;

    localparam logic [31:0] WMASK    = 32'((64'd1 << GPIO_WIDTH) - 64'd1);
    localparam logic [31:0] CFG_MASK = {WMASK[15:0], WMASK[15:0]};
    localparam logic [31:0] OUT_RST  = 32'(OUT_RESET) & WMASK;
    localparam logic [2:0]  FILL_N   = 3'(SYNC_STAGES + 1);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] irq_en_q, irq_en_d;
    logic [31:0] irq_cfg_q, irq_cfg_d;
    logic [31:0] status_q, status_d;
    logic [31:0] hit_q, hit_d;
    logic [2:0]  fill_q, fill_d;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q, sync_d;
    logic [GPIO_WIDTH-1:0] prev_q, prev_d;

    logic        access;
    logic        wr;
    logic        fill_done;
    reg_addr_e   addr;
    logic [31:0] bmask;
    logic [31:0] wbits;
    logic [31:0] rdata;
    logic [31:0] pin_s, pin_p;
    logic [31:0] typ, pol, rise, fall;
    logic        unused_adr;

    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
        assign gpio_b[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

    always_comb begin
        access    = wb_cyc_i & wb_stb_i & ~ack_q;
        wr        = access & wb_we_i;
        addr      = reg_addr_e'(wb_adr_i[4:2]);
        bmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wbits     = wb_dat_i & bmask;
        fill_done = (fill_q == FILL_N);

        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_b};
        // During the post-reset fill the delayed copy tracks the synchroniser output so no
        // spurious edge is seen; detection as a whole stays off until the fill completes.
        prev_d = fill_done ? sync_q[SYNC_STAGES-1] : sync_d[SYNC_STAGES-1];
        fill_d = fill_done ? fill_q : fill_q + 3'd1;

        pin_s = 32'(sync_q[SYNC_STAGES-1]);
        pin_p = 32'(prev_q);
        typ   = {16'hFFFF, irq_cfg_q[15:0]};
        pol   = {16'hFFFF, irq_cfg_q[31:16]};
        rise  = pin_s & ~pin_p;
        fall  = ~pin_s & pin_p;
        hit_d = '0;
        if (fill_done) begin
            hit_d = WMASK & ((typ & ((pol & rise) | (~pol & fall))) | (~typ & ~(pin_s ^ pol)));
        end

        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_cfg_d  = irq_cfg_q;
        status_d   = status_q;
        if (wr) begin
            case (addr)
                A_DATA_OUT: data_out_d = ((data_out_q & ~bmask) | wbits) & WMASK;
                A_DIR:      dir_d      = ((dir_q & ~bmask) | wbits) & WMASK;
                A_DATA_IN:  status_d   = status_q & ~wbits;
                A_OUT_SET:  data_out_d = (data_out_q | wbits) & WMASK;
                A_OUT_CLR:  data_out_d = data_out_q & ~wbits;
                A_OUT_TGL:  data_out_d = (data_out_q ^ wbits) & WMASK;
                A_IRQ_EN:   irq_en_d   = ((irq_en_q & ~bmask) | wbits) & WMASK;
                A_IRQ_CFG:  irq_cfg_d  = ((irq_cfg_q & ~bmask) | wbits) & CFG_MASK;
                default:    ;
            endcase
        end
        // A new event on the same edge as its W1C keeps the bit set.
        status_d = (status_d | hit_q) & WMASK;

        case (addr)
            A_DATA_OUT: rdata = data_out_q;
            A_DIR:      rdata = dir_q;
            A_DATA_IN:  rdata = pin_s;
            A_OUT_SET:  rdata = status_q;
            A_IRQ_EN:   rdata = irq_en_q;
            A_IRQ_CFG:  rdata = irq_cfg_q;
            default:    rdata = '0;
        endcase

        ack_d = access;
        dat_d = access ? rdata : '0;
        irq_d = |(status_q & irq_en_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
            data_out_q <= OUT_RST;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_cfg_q  <= '0;
            status_q   <= '0;
            hit_q      <= '0;
            fill_q     <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_cfg_q  <= irq_cfg_d;
            status_q   <= status_d;
            hit_q      <= hit_d;
            fill_q     <= fill_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Bench for wb_gpio_irq: directed bus/interrupt steps plus randomized register traffic
// checked against a byte-lane register model and the pin drive the bench itself applies.
module tb_wb_gpio_irq;

    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, din;
    logic [31:0] dout;
    logic        ack;
    logic        irq;
    wire [W-1:0] gpio_b;

    logic [W-1:0] tb_oe;
    logic [W-1:0] tb_val;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_out, m_dir, m_en, m_cfg;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign gpio_b[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    wb_gpio_irq #(
        .GPIO_WIDTH (32),
        .SYNC_STAGES(2),
        .OUT_RESET  (32'h0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i (we),
        .wb_sel_i(sel),
        .wb_adr_i(adr),
        .wb_dat_i(din),
        .wb_dat_o(dout),
        .wb_ack_o(ack),
        .gpio_b  (gpio_b),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        return (old & ~lanes(s)) | (d & lanes(s));
    endfunction

    // Register-level view of what each readable slot should return (status excluded).
    function automatic logic [31:0] expect_read(input logic [2:0] slot);
        case (slot)
            3'd0:    return m_out;
            3'd1:    return m_dir;
            3'd2:    return (m_out & m_dir) | (tb_val & ~m_dir);
            3'd6:    return m_en;
            3'd7:    return m_cfg;
            default: return 32'h0;
        endcase
    endfunction

    task automatic xfer(input logic w, input logic [2:0] slot, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] q);
        int unsigned n;
        logic [31:0] a;
        @(posedge clk); #1;
        a      = $urandom;
        a[4:2] = slot;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; din = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        check("ack_latency", n, 1);
        q   = dout;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_single", 32'(ack), 0);
        check("dat_idle", dout, 0);
    endtask

    task automatic wr(input logic [2:0] slot, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        logic [31:0] nd;
        nd = m_dir;
        if (slot == 3'd1) begin
            nd    = merge(m_dir, d, s);
            tb_oe = ~(m_dir | nd);
        end
        xfer(1'b1, slot, s, d, q);
        case (slot)
            3'd0: m_out = merge(m_out, d, s);
            3'd1: m_dir = nd;
            3'd3: m_out = m_out | (d & lanes(s));
            3'd4: m_out = m_out & ~(d & lanes(s));
            3'd5: m_out = m_out ^ (d & lanes(s));
            3'd6: m_en  = merge(m_en, d, s);
            3'd7: m_cfg = merge(m_cfg, d, s);
            default: ;
        endcase
        tb_oe = ~m_dir;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] slot, input logic [31:0] exp);
        logic [31:0] q;
        xfer(1'b0, slot, 4'($urandom), $urandom, q);
        check(tag, q, exp);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; din = '0;
        tb_oe  = '1;
        tb_val = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_out = 32'h0; m_dir = 32'h0; m_en = 32'h0; m_cfg = 32'h0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    logic [2:0]  r_slot;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic        r_we;

    initial begin
        reset_dut();
        check("rst_irq", 32'(irq), 0);
        for (int s = 0; s < 8; s++) begin
            rd_chk("rst_read", 3'(s), expect_read(3'(s)));
        end

        wr(3'd1, 32'h0000_00FF, 4'hF);
        wr(3'd0, 32'h0000_00A5, 4'hF);
        wr(3'd5, 32'h0000_000F, 4'hF);
        check("pads_aa", 32'(gpio_b[7:0]), 32'hAA);
        check("model_aa", m_out, 32'hAA);
        repeat (2) @(posedge clk);
        #1;
        rd_chk("data_in_aa", 3'd2, {tb_val[31:8], 8'hAA});

        wr(3'd0, 32'h0, 4'hF);
        wr(3'd0, 32'hFFFF_FFFF, 4'b0010);
        rd_chk("sel_lane", 3'd0, 32'h0000_FF00);

        wr(3'd7, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_001C;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("held_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("held_dat", dout, (i % 2 == 0) ? 32'h1234_5678 : 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 48; i++) begin
            tb_val = $urandom;
            r_slot = 3'($urandom_range(0, 7));
            r_we   = 1'($urandom_range(0, 1));
            r_sel  = 4'($urandom);
            r_dat  = $urandom;
            if (r_we) begin
                wr(r_slot, r_dat, r_sel);
            end else begin
                if (r_slot == 3'd3) r_slot = 3'd6;
                if (r_slot == 3'd2) begin
                    repeat (3) @(posedge clk);
                    #1;
                end
                rd_chk("rand_rd", r_slot, expect_read(r_slot));
            end
        end

        reset_dut();
        tb_oe = ~32'h0000_FFFF;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0000_0004; din = 32'h0000_FFFF;
        @(posedge clk); #1;
        check("rst_ack_hi", 32'(ack), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_ack_drop", 32'(ack), 0);
        check("rst_dat_drop", dout, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tb_oe = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_out = 32'h0; m_dir = 32'h0; m_en = 32'h0; m_cfg = 32'h0;
        repeat (5) @(posedge clk);
        #1;
        rd_chk("rst_dir_lost", 3'd1, 32'h0);
        rd_chk("fill_no_edge", 3'd3, 32'h0);

        wr(3'd7, 32'h0000_0008, 4'hF);
        wr(3'd6, 32'h0000_0008, 4'hF);
        @(posedge clk); #1;
        tb_val[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("edge_irq_k3", 32'(irq), 0);
        @(posedge clk); #1;
        check("edge_irq_k4", 32'(irq), 1);
        rd_chk("edge_status", 3'd3, 32'h0000_0008);
        wr(3'd2, 32'h0000_0008, 4'hF);
        check("w1c_irq_low", 32'(irq), 0);
        rd_chk("w1c_status", 3'd3, 32'h0);

        tb_val[20] = 1'b0;
        repeat (5) @(posedge clk);
        #1 tb_val[20] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd_chk("rise20_status", 3'd3, 32'h0010_0000);
        check("rise20_masked", 32'(irq), 0);
        wr(3'd6, 32'h0010_0008, 4'hF);
        check("en_late_irq", 32'(irq), 1);
        wr(3'd2, 32'h0010_0000, 4'hF);
        check("rise20_clr", 32'(irq), 0);

        wr(3'd7, 32'h0020_0008, 4'hF);
        wr(3'd6, 32'h0000_0028, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("lvl_irq", 32'(irq), 1);
        wr(3'd2, 32'h0000_0020, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rd_chk("lvl_sticky", 3'd3, 32'h0000_0020);
        tb_val[5] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        wr(3'd2, 32'h0000_0020, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        rd_chk("lvl_cleared", 3'd3, 32'h0);
        check("lvl_irq_low", 32'(irq), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
